// File: rtl/piarb_asa_lkup_pkg.sv
// piarb_asa_lkup_pkg
//   Shared widths and metadata types for the piarb ASA lookup stage.
//   piarb_asa_meta_type : entry popped from the piarb ASA metadata FIFO.
//   asa_lkup_meta_type  : that entry merged with the data read from the ASA table.
package piarb_asa_lkup_pkg;

    localparam int unsigned ASA_ID_NBITS   = 6;
    localparam int unsigned ASA_DATA_NBITS = 16;
    localparam int unsigned PORT_NBITS     = 4;
    localparam int unsigned TAG_NBITS      = 8;

    typedef struct packed {
        logic [PORT_NBITS-1:0]   port;
        logic [TAG_NBITS-1:0]    tag;
        logic [ASA_ID_NBITS-1:0] asa_id;
    } piarb_asa_meta_type;

    typedef struct packed {
        piarb_asa_meta_type        meta;
        logic [ASA_DATA_NBITS-1:0] asa_data;
    } asa_lkup_meta_type;

endpackage

// File: rtl/sfifo_asa_lkup.sv
// sfifo_asa_lkup
//   Output buffer of the ASA lookup stage: synchronous FIFO of asa_lkup_meta_type,
//   2**NBITS entries, head read straight out of the storage flops.
//   Ports:
//     clk, rst     clock, synchronous active-high reset (clears pointers and count)
//     push, wdata  write request and data
//     pop          read request (ignored when empty)
//     rdata        head entry, meaningful while ~empty
//     empty, full  status flags
//     count        occupancy, 0..2**NBITS (used by the caller's credit check)
module sfifo_asa_lkup
    import piarb_asa_lkup_pkg::*;
#(
    parameter int unsigned NBITS = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  asa_lkup_meta_type wdata,
    input  logic              pop,
    output asa_lkup_meta_type rdata,
    output logic              empty,
    output logic              full,
    output logic [NBITS:0]    count
);

    localparam int unsigned    DEPTH   = 1 << NBITS;
    localparam logic [NBITS:0] DEPTH_W = (NBITS + 1)'(DEPTH);

    asa_lkup_meta_type mem_q [DEPTH];
    logic [NBITS-1:0]  wr_ptr_q;
    logic [NBITS-1:0]  rd_ptr_q;
    logic [NBITS:0]    count_q;
    logic [NBITS:0]    count_d;
    logic              do_push;
    logic              do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_W);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    assign do_pop  = pop & ~empty;
    // When full, a same-cycle pop frees the head slot, which is exactly where wr_ptr points.
    assign do_push = push & (~full | do_pop);

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (NBITS + 1)'(1);
            2'b01:   count_d = count_q - (NBITS + 1)'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + NBITS'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + NBITS'(1);
            count_q <= count_d;
        end
    end

    // Storage needs no reset: nothing is visible until count says so.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/piarb_asa_lkup.sv
// piarb_asa_lkup
//   Pops piarb ASA metadata entries, reads the ASA table at entry.asa_id with a fixed
//   latency, merges the returned data with the metadata and hands the result on through
//   a valid/ready output buffer. Issue is credit gated so the buffer can never overflow.
//   Optional build macro: PIARB_ASA_LKUP_STATS_EN adds lkup_cnt / stall_cnt outputs.
//   Reset port name comes from `RESET_SIG (defaults to rst); reset is synchronous,
//   active-high.
//   Ports:
//     clk                      clock
//     `RESET_SIG               synchronous reset
//     enable                   0 holds off new lookups; in-flight lookups complete
//     fifo_empty, fifo_dout    upstream FIFO status / head entry
//     fifo_rd                  upstream pop (combinational, equals tbl_rd)
//     tbl_rd, tbl_addr         ASA table read strobe / address
//     tbl_rdata                table data, valid LKUP_LAT cycles after tbl_rd
//     out_valid, out_meta      output buffer head
//     out_ready                downstream accept
//     lkup_cnt, stall_cnt      (stats build only) issue count / credit-stall cycles
//     busy                     lookup in flight or output buffer non-empty
`ifndef RESET_SIG
`define RESET_SIG rst
`endif

module piarb_asa_lkup
    import piarb_asa_lkup_pkg::*;
#(
    parameter int unsigned LKUP_LAT  = 3,
    parameter int unsigned OUT_NBITS = 3
) (
    input  logic                      clk,
    input  logic                      `RESET_SIG,
    input  logic                      enable,
    input  logic                      fifo_empty,
    input  piarb_asa_meta_type        fifo_dout,
    output logic                      fifo_rd,
    output logic                      tbl_rd,
    output logic [ASA_ID_NBITS-1:0]   tbl_addr,
    input  logic [ASA_DATA_NBITS-1:0] tbl_rdata,
    output logic                      out_valid,
    output asa_lkup_meta_type         out_meta,
    input  logic                      out_ready,
`ifdef PIARB_ASA_LKUP_STATS_EN
    output logic [31:0]               lkup_cnt,
    output logic [31:0]               stall_cnt,
`endif
    output logic                      busy
);

    localparam int unsigned        OUT_DEPTH   = 1 << OUT_NBITS;
    localparam int unsigned        CNT_NBITS   = OUT_NBITS + 1;
    localparam logic [CNT_NBITS:0] OUT_DEPTH_W = (CNT_NBITS + 1)'(OUT_DEPTH);

    logic                 issue;
    logic                 credit_ok;
    logic                 retire;
    logic                 obuf_empty;
    logic                 obuf_full;
    logic                 obuf_pop;
    logic [CNT_NBITS-1:0] obuf_count;
    logic [CNT_NBITS-1:0] inflight_q;
    logic [CNT_NBITS-1:0] inflight_d;
    logic [CNT_NBITS:0]   outstanding;
    asa_lkup_meta_type    retire_data;

    logic                 pipe_vld_q  [LKUP_LAT];
    piarb_asa_meta_type   pipe_meta_q [LKUP_LAT];

    // Every issued entry holds a buffer slot from issue until it is popped downstream,
    // so the buffer can absorb all in-flight results no matter how long out_ready stalls.
    assign outstanding = {1'b0, inflight_q} + {1'b0, obuf_count};
    assign credit_ok   = (outstanding < OUT_DEPTH_W);
    assign issue       = enable & ~fifo_empty & credit_ok;

    assign fifo_rd  = issue;
    assign tbl_rd   = issue;
    assign tbl_addr = fifo_dout.asa_id;

    // Lookup pipeline: metadata travels alongside the table read.
    always_ff @(posedge clk) begin
        if (`RESET_SIG) pipe_vld_q[0] <= 1'b0;
        else            pipe_vld_q[0] <= issue;
    end

    always_ff @(posedge clk) begin
        pipe_meta_q[0] <= fifo_dout;
    end

    for (genvar i = 1; i < LKUP_LAT; i++) begin : g_stage
        always_ff @(posedge clk) begin
            if (`RESET_SIG) pipe_vld_q[i] <= 1'b0;
            else            pipe_vld_q[i] <= pipe_vld_q[i-1];
        end

        always_ff @(posedge clk) begin
            pipe_meta_q[i] <= pipe_meta_q[i-1];
        end
    end

    // Table data lines up with the last stage; data for flushed lookups is dropped here.
    assign retire               = pipe_vld_q[LKUP_LAT-1];
    assign retire_data.meta     = pipe_meta_q[LKUP_LAT-1];
    assign retire_data.asa_data = tbl_rdata;

    always_comb begin
        inflight_d = inflight_q;
        unique case ({issue, retire})
            2'b10:   inflight_d = inflight_q + CNT_NBITS'(1);
            2'b01:   inflight_d = inflight_q - CNT_NBITS'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (`RESET_SIG) inflight_q <= '0;
        else            inflight_q <= inflight_d;
    end

    assign out_valid = ~obuf_empty;
    assign obuf_pop  = out_valid & out_ready;
    assign busy      = (inflight_q != '0) | out_valid;

    sfifo_asa_lkup #(
        .NBITS (OUT_NBITS)
    ) u_obuf (
        .clk   (clk),
        .rst   (`RESET_SIG),
        .push  (retire),
        .wdata (retire_data),
        .pop   (obuf_pop),
        .rdata (out_meta),
        .empty (obuf_empty),
        .full  (obuf_full),
        .count (obuf_count)
    );

`ifdef PIARB_ASA_LKUP_STATS_EN
    always_ff @(posedge clk) begin
        if (`RESET_SIG) begin
            lkup_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (issue) lkup_cnt <= lkup_cnt + 32'd1;
            // Saturates so a long stall never reads back as a small number.
            if (enable & ~fifo_empty & ~credit_ok & (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

`ifndef SYNTHESIS
    // A result arriving with no room and no pop would be lost.
    a_obuf_overflow: assert property (@(posedge clk) disable iff (`RESET_SIG)
        !(retire && obuf_full && !obuf_pop));
    a_inflight_underflow: assert property (@(posedge clk) disable iff (`RESET_SIG)
        !(retire && (inflight_q == '0)));
`endif

endmodule
